// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and op-class helpers shared by the ALU and its arbiter.
package alu_pkg;
    typedef logic [3:0] aluop_t;
    localparam aluop_t ALU_ADD   = 4'd0;
    localparam aluop_t ALU_SUB   = 4'd1;
    localparam aluop_t ALU_SLL   = 4'd2;
    localparam aluop_t ALU_SLT   = 4'd3;
    localparam aluop_t ALU_SLTU  = 4'd4;
    localparam aluop_t ALU_XOR   = 4'd5;
    localparam aluop_t ALU_SRL   = 4'd6;
    localparam aluop_t ALU_SRA   = 4'd7;
    localparam aluop_t ALU_OR    = 4'd8;
    localparam aluop_t ALU_AND   = 4'd9;
    localparam aluop_t ALU_PASSB = 4'd15;

    function automatic logic is_illegal(aluop_t op);
        return (op >= 4'd10) && (op <= 4'd14);
    endfunction

    function automatic logic is_shift(aluop_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit integer ALU.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:   y_o = a_i + b_i;
            ALU_SUB:   y_o = a_i - b_i;
            ALU_SLL:   y_o = a_i << b_i[4:0];
            ALU_SLT:   y_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:  y_o = {31'b0, a_i < b_i};
            ALU_XOR:   y_o = a_i ^ b_i;
            ALU_SRL:   y_o = a_i >> b_i[4:0];
            ALU_SRA:   y_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_OR:    y_o = a_i | b_i;
            ALU_AND:   y_o = a_i & b_i;
            ALU_PASSB: y_o = b_i;
            default:   y_o = '0;
        endcase
    end
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way arbiter, round-robin or fixed-priority (requester 0 wins).
module rr_arb2 #(
    parameter int FAIR = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic accept_i,
    output logic gnt_o
);
    logic last_q, last_d;

    // Resetting last to 1 lets requester 0 win the first conflict.
    assign gnt_o  = (valid0_i & valid1_i) ? ((FAIR != 0) ? ~last_q : 1'b0) : valid1_i;
    assign last_d = accept_i ? gnt_o : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one ALU between two requesters behind a registered,
// back-pressured response channel tagged with the requester id.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int FAIR = 1,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err
);
    logic            gnt, out_free, accept, bad;
    logic [3:0]      sel_op, alu_op;
    logic [XLEN-1:0] sel_a, sel_b, alu_b, alu_y;
    logic            rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;

    rr_arb2 #(.FAIR(FAIR)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign out_free   = ~rsp_valid_q | rsp_ready;
    assign req0_ready = ~gnt & out_free & req0_valid;
    assign req1_ready = gnt & out_free & req1_valid;
    assign accept     = req0_ready | req1_ready;

    assign sel_op = gnt ? req1_op : req0_op;
    assign sel_a  = gnt ? req1_a  : req0_a;
    assign sel_b  = gnt ? req1_b  : req0_b;
    assign bad    = is_illegal(sel_op);

    // Illegal ops become pass-B of zero so the result is a clean 0.
    assign alu_op = bad ? ALU_PASSB : sel_op;
    assign alu_b  = bad ? '0 : is_shift(sel_op) ? {{(XLEN-5){1'b0}}, sel_b[4:0]} : sel_b;

    alu u_alu (
        .op_i (alu_op),
        .a_i  (sel_a),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    always_comb begin
        rsp_valid_d = accept ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_id_d    = accept ? gnt : rsp_id_q;
        rsp_data_d  = accept ? alu_y : rsp_data_q;
        rsp_err_d   = accept ? bad : rsp_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed vector table, hand-written corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_alu_share_arb;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, rdy = 1'b1;
    logic [3:0]  op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        r0_f, r1_f, rv_f, rid_f, rerr_f;
    logic [31:0] rdat_f;
    logic        r0_p, r1_p, rv_p, rid_p, rerr_p;
    logic [31:0] rdat_p;

    int n_chk = 0, n_bad = 0;
    logic        m_valid, m_id, m_err, m_last, h0, h1;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    alu_share_arb #(.FAIR(1), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(r0_f), .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(r1_f), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(rv_f), .rsp_ready(rdy), .rsp_id(rid_f), .rsp_data(rdat_f), .rsp_err(rerr_f)
    );

    alu_share_arb #(.FAIR(0), .XLEN(32)) dut_prio (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(r0_p), .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(r1_p), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(rv_p), .rsp_ready(rdy), .rsp_id(rid_p), .rsp_data(rdat_p), .rsp_err(rerr_p)
    );

    typedef struct {
        logic v0; logic [3:0] op0; logic [31:0] a0, b0;
        logic v1; logic [3:0] op1; logic [31:0] a1, b1;
        logic rdy, er0, er1, ev, eid; logic [31:0] ed; logic ee;
    } vec_t;

    function automatic vec_t mk(logic v0_, logic [3:0] op0_, logic [31:0] a0_, logic [31:0] b0_,
                                logic v1_, logic [3:0] op1_, logic [31:0] a1_, logic [31:0] b1_,
                                logic rdy_, logic er0_, logic er1_, logic ev_, logic eid_,
                                logic [31:0] ed_, logic ee_);
        vec_t t;
        t.v0 = v0_; t.op0 = op0_; t.a0 = a0_; t.b0 = b0_;
        t.v1 = v1_; t.op1 = op1_; t.a1 = a1_; t.b1 = b1_;
        t.rdy = rdy_; t.er0 = er0_; t.er1 = er1_; t.ev = ev_; t.eid = eid_; t.ed = ed_; t.ee = ee_;
        return t;
    endfunction

    // Reference ALU from the op definitions, with illegal ops yielding 0.
    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned sh = b % 32;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a << sh;
            3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4: return (a < b) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6: return a >> sh;
            7: return $unsigned($signed(a) >>> sh);
            8: return a | b;
            9: return a & b;
            15: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which requester the model would let through right now.
    task automatic model_ready(output logic mr0, output logic mr1);
        logic g, fr;
        g   = (v0 && v1) ? ~m_last : v1;
        fr  = !m_valid || rdy;
        mr0 = v0 && fr && !g;
        mr1 = v1 && fr && g;
    endtask

    task automatic model_check();
        logic mr0, mr1;
        model_ready(mr0, mr1);
        chk("rnd req0_ready", 32'(r0_f), 32'(mr0));
        chk("rnd req1_ready", 32'(r1_f), 32'(mr1));
        chk("rnd rsp_valid", 32'(rv_f), 32'(m_valid));
        chk("rnd rsp_id", 32'(rid_f), 32'(m_id));
        chk("rnd rsp_data", rdat_f, m_data);
        chk("rnd rsp_err", 32'(rerr_f), 32'(m_err));
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_err = 0; m_data = 0; m_last = 1; h0 = 0; h1 = 0;
    endtask

    task automatic advance();
        logic mr0, mr1;
        model_ready(mr0, mr1);
        @(posedge clk);
        if (mr0 || mr1) begin
            m_valid = 1;
            m_id    = mr1;
            m_last  = mr1;
            m_data  = mr1 ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
            m_err   = mr1 ? (op1 inside {[10:14]}) : (op0 inside {[10:14]});
        end else if (rdy) begin
            m_valid = 0;
        end
        h0 = v0 && !mr0;
        h1 = v1 && !mr1;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; v0 = 0; v1 = 0; rdy = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rsp_valid", 32'(rv_f), 0);
        chk("reset rsp_data", rdat_f, 0);
        chk("reset prio rsp_valid", 32'(rv_p), 0);
        rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[18];

    initial begin
        tbl[0]  = mk(1, 0, 5, 3,                      0, 0, 0, 0,                 1, 1, 0, 0, 0, 32'h0, 0);
        tbl[1]  = mk(1, 1, 3, 5,                      1, 4, 1, 32'hFFFFFFFF,      1, 0, 1, 1, 0, 32'd8, 0);
        tbl[2]  = mk(1, 1, 3, 5,                      1, 4, 1, 32'hFFFFFFFF,      1, 1, 0, 1, 1, 32'd1, 0);
        tbl[3]  = mk(1, 1, 3, 5,                      1, 4, 1, 32'hFFFFFFFF,      1, 0, 1, 1, 0, 32'hFFFFFFFE, 0);
        tbl[4]  = mk(1, 1, 3, 5,                      1, 4, 1, 32'hFFFFFFFF,      1, 1, 0, 1, 1, 32'd1, 0);
        tbl[5]  = mk(1, 7, 32'h80000000, 32'h24,      0, 0, 0, 0,                 1, 1, 0, 1, 0, 32'hFFFFFFFE, 0);
        tbl[6]  = mk(1, 2, 1, 31,                     0, 0, 0, 0,                 1, 1, 0, 1, 0, 32'hF8000000, 0);
        tbl[7]  = mk(0, 0, 0, 0,                      1, 12, 7, 9,                1, 0, 1, 1, 0, 32'h80000000, 0);
        tbl[8]  = mk(0, 0, 0, 0,                      1, 0, 2, 2,                 1, 0, 1, 1, 1, 32'h0, 1);
        tbl[9]  = mk(0, 0, 0, 0,                      0, 0, 0, 0,                 1, 0, 0, 1, 1, 32'd4, 0);
        tbl[10] = mk(0, 0, 0, 0,                      0, 0, 0, 0,                 1, 0, 0, 0, 1, 32'd4, 0);
        tbl[11] = mk(1, 5, 32'hF0F0, 32'h0FF0,        0, 0, 0, 0,                 1, 1, 0, 0, 1, 32'd4, 0);
        tbl[12] = mk(0, 0, 0, 0,                      1, 8, 32'h100, 1,           0, 0, 0, 1, 0, 32'hFF00, 0);
        tbl[13] = mk(0, 0, 0, 0,                      1, 8, 32'h100, 1,           0, 0, 0, 1, 0, 32'hFF00, 0);
        tbl[14] = mk(0, 0, 0, 0,                      1, 8, 32'h100, 1,           0, 0, 0, 1, 0, 32'hFF00, 0);
        tbl[15] = mk(0, 0, 0, 0,                      1, 8, 32'h100, 1,           1, 0, 1, 1, 0, 32'hFF00, 0);
        tbl[16] = mk(0, 0, 0, 0,                      0, 0, 0, 0,                 1, 0, 0, 1, 1, 32'h101, 0);
        tbl[17] = mk(0, 0, 0, 0,                      0, 0, 0, 0,                 1, 0, 0, 0, 1, 32'h101, 0);

        model_reset();
        do_reset();

        for (int i = 0; i < 18; i++) begin
            v0 = tbl[i].v0; op0 = tbl[i].op0; a0 = tbl[i].a0; b0 = tbl[i].b0;
            v1 = tbl[i].v1; op1 = tbl[i].op1; a1 = tbl[i].a1; b1 = tbl[i].b1;
            rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d req0_ready", i), 32'(r0_f), 32'(tbl[i].er0));
            chk($sformatf("tbl%0d req1_ready", i), 32'(r1_f), 32'(tbl[i].er1));
            chk($sformatf("tbl%0d rsp_valid", i), 32'(rv_f), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d rsp_id", i), 32'(rid_f), 32'(tbl[i].eid));
            chk($sformatf("tbl%0d rsp_data", i), rdat_f, tbl[i].ed);
            chk($sformatf("tbl%0d rsp_err", i), 32'(rerr_f), 32'(tbl[i].ee));
            advance();
        end

        // Fixed priority: requester 0 always wins while both are valid.
        do_reset();
        v0 = 1; op0 = 0; a0 = 1; b0 = 1;
        v1 = 1; op1 = 0; a1 = 2; b1 = 2;
        rdy = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("prio%0d req0_ready", i), 32'(r0_p), 1);
            chk($sformatf("prio%0d req1_ready", i), 32'(r1_p), 0);
            if (i > 0) chk($sformatf("prio%0d rsp_data", i), rdat_p, 2);
            advance();
        end

        // Asynchronous reset mid-stream drops the pending response at once.
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async rst rsp_valid", 32'(rv_f), 0);
        chk("async rst prio rsp_valid", 32'(rv_p), 0);
        chk("async rst rsp_data", rdat_f, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        #1;
        chk("post-rst req0_ready", 32'(r0_f), 1);
        chk("post-rst req1_ready", 32'(r1_f), 0);
        advance();

        // Randomized traffic; operands held while waiting for acceptance.
        for (int i = 0; i < 400; i++) begin
            if (!h0) begin
                v0 = ($urandom_range(0, 3) != 0);
                op0 = 4'($urandom_range(0, 15));
                a0 = $urandom; b0 = $urandom;
            end
            if (!h1) begin
                v1 = ($urandom_range(0, 3) != 0);
                op1 = 4'($urandom_range(0, 15));
                a1 = $urandom; b1 = $urandom;
            end
            rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_check();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
